// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants and state encoding for the data memory arbiter
// Contents:
//   WORD        data/address width of the datapath
//   DMEM_DEPTH  number of doubleword entries in the data memory
//   dma_state_t arbiter sequencer states
package dmem_arbiter_pkg;

  localparam int WORD       = 64;
  localparam int DMEM_DEPTH = 64;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_ISSUE = 2'd1,
    DMA_RESP  = 2'd2
  } dma_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// rtl/dmem_arbiter_rr_arbiter2.sv - combinational two-input round-robin pick
// Ports:
//   req        in  2  pending requests, bit n = requester n
//   last_grant in  1  index of the requester served most recently
//   grant      out 2  one-hot grant, all zero when no request is pending
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the requester that was not served last wins.
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer in front of the single-ported data memory
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rN_req/we/addr/wdata            requester N access request (held until ack)
//   rN_ack/err/rdata                requester N one-cycle completion, error flag, load data
//   mem_address/write_data          address and store data to the memory
//   mem_read/mem_write              memory strobes, asserted only in ISSUE
//   mem_read_data                   registered memory output, valid one cycle after mem_read
//   busy                            high whenever the sequencer is not idle
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [WIDTH-1:0] r0_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_ack,
  output logic             r0_err,
  output logic [WIDTH-1:0] r0_rdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [WIDTH-1:0] r1_addr,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_ack,
  output logic             r1_err,
  output logic [WIDTH-1:0] r1_rdata,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ADDR_LIMIT = WIDTH'(DEPTH * 8);

  dma_state_t       state, state_next;
  logic             last_grant;
  logic             gnt_id;
  logic             we_q;
  logic             err_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;

  logic [1:0]       grant;
  logic             sel;
  logic             sel_we;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_bad;

  rr_arbiter2 u_rr (
    .req        ({r1_req, r0_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Mux the winning requester's fields and check them before anything is issued.
  always_comb begin
    sel       = grant[1];
    sel_we    = sel ? r1_we    : r0_we;
    sel_addr  = sel ? r1_addr  : r0_addr;
    sel_wdata = sel ? r1_wdata : r0_wdata;
    sel_bad   = (sel_addr[2:0] != 3'd0) || (sel_addr >= ADDR_LIMIT);
  end

  // State register plus the request latched at grant time.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DMA_IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_next;
      if (state == DMA_IDLE && grant != 2'b00) begin
        last_grant <= sel;
        gnt_id     <= sel;
        we_q       <= sel_we;
        err_q      <= sel_bad;
        // A rejected request leaves the memory-facing address/data untouched.
        if (!sel_bad) begin
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DMA_IDLE: begin
        if (grant != 2'b00) state_next = sel_bad ? DMA_RESP : DMA_ISSUE;
      end
      DMA_ISSUE: state_next = DMA_RESP;
      DMA_RESP:  state_next = DMA_IDLE;
      default:   state_next = DMA_IDLE;
    endcase
  end

  // Strobes and responses are gated by reset so an in-flight access is dropped at once.
  always_comb begin
    mem_address    = addr_q;
    mem_write_data = wdata_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    r0_ack         = 1'b0;
    r0_err         = 1'b0;
    r0_rdata       = '0;
    r1_ack         = 1'b0;
    r1_err         = 1'b0;
    r1_rdata       = '0;
    busy           = (state != DMA_IDLE);
    case (state)
      DMA_ISSUE: begin
        mem_read  = !we_q && !reset;
        mem_write = we_q && !reset;
      end
      DMA_RESP: begin
        if (!reset) begin
          if (gnt_id) begin
            r1_ack   = 1'b1;
            r1_err   = err_q;
            r1_rdata = (!err_q && !we_q) ? mem_read_data : '0;
          end else begin
            r0_ack   = 1'b1;
            r0_err   = err_q;
            r0_rdata = (!err_q && !we_q) ? mem_read_data : '0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural memory and reference model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [63:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [63:0] r0_rdata, r1_rdata;
  logic [63:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, busy;

  logic        mem_init;
  logic [63:0] mem [0:63];
  logic [63:0] ref_mem [0:63];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  logic        last_served;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  function automatic logic [63:0] init_val(input int i);
    return 64'hA5A5_0000_0000_0000 ^ (64'(i) * 64'h0101_0101);
  endfunction

  // Single-ported memory with a registered read port.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_read_data <= '0;
    end else begin
      if (mem_write && mem_address < 64'd512) mem[mem_address[8:3]] <= mem_write_data;
      if (mem_read) mem_read_data <= (mem_address < 64'd512) ? mem[mem_address[8:3]] : 64'd0;
    end
  end

  always @(posedge clk) begin
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read)  rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one request on each enabled port, predict grant order, latency and data, then check.
  task automatic run_txn(input string tag, input logic v0, input logic v1,
                         input logic w0, input logic w1,
                         input logic [63:0] a0, input logic [63:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
    logic [63:0] a[2], d[2], rd[2];
    logic        w[2], v[2], bad[2];
    int          e[2];
    int          ord[2];
    int          n, t, nwr, nrd, wr0, rd0, first_end, last_end;
    logic        exp_busy;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    w[0] = w0; w[1] = w1; v[0] = v0; v[1] = v1;
    e[0] = -1; e[1] = -1; rd[0] = '0; rd[1] = '0;
    nwr = 0; nrd = 0; t = 0;
    for (int i = 0; i < 2; i++) bad[i] = (a[i][2:0] != 3'd0) || (a[i] >= 64'd512);
    if (v0 && v1) begin
      n = 2;
      ord[0] = last_served ? 0 : 1;
      ord[1] = 1 - ord[0];
    end else begin
      n = 1;
      ord[0] = v0 ? 0 : 1;
      ord[1] = 1 - ord[0];
    end
    for (int j = 0; j < n; j++) begin
      int r;
      r = ord[j];
      t = t + (j == 0 ? 0 : 1) + (bad[r] ? 1 : 2);
      e[r] = t;
      if (!bad[r]) begin
        if (w[r]) begin
          ref_mem[a[r][8:3]] = d[r];
          nwr++;
        end else begin
          rd[r] = ref_mem[a[r][8:3]];
          nrd++;
        end
      end
      last_served = r[0];
    end
    first_end = e[ord[0]];
    last_end  = t;
    wr0 = wr_cnt; rd0 = rd_cnt;
    r0_req = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    for (int k = 1; k <= last_end + 1; k++) begin
      step();
      exp_busy = (k <= first_end) || (n == 2 && k >= first_end + 2 && k <= last_end);
      check({tag, "_ack0"}, r0_ack, (k == e[0]));
      check({tag, "_ack1"}, r1_ack, (k == e[1]));
      check({tag, "_busy"}, busy, exp_busy);
      if (k == e[0]) begin
        check({tag, "_err0"}, r0_err, bad[0]);
        check({tag, "_rdata0"}, r0_rdata, rd[0]);
        r0_req = 1'b0;
      end
      if (k == e[1]) begin
        check({tag, "_err1"}, r1_err, bad[1]);
        check({tag, "_rdata1"}, r1_rdata, rd[1]);
        r1_req = 1'b0;
      end
    end
    check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(nwr));
    check({tag, "_reads"}, 64'(rd_cnt - rd0), 64'(nrd));
  endtask

  function automatic logic [63:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return {55'd0, 6'($urandom_range(0, 63)), 3'b000};
    else if (sel == 7) return {55'd0, 6'($urandom_range(0, 63)), 3'($urandom_range(1, 7))};
    else if (sel == 8) return (64'($urandom_range(0, 1000)) << 3) + 64'd512;
    else               return ($urandom_range(0, 1) != 0) ? 64'h1F8 : 64'hFFFF_FFFF_FFFF_FFF8;
  endfunction

  initial begin
    int wr0;
    reset = 1'b1; mem_init = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    last_served = 1'b1;
    repeat (3) step();
    reset = 1'b0; mem_init = 1'b0;
    step();

    check("rst_busy", busy, 1'b0);
    check("rst_acks", {r0_ack, r1_ack, r0_err, r1_err}, 4'b0);
    check("rst_strobes", {mem_read, mem_write}, 2'b0);
    check("rst_rdata", r0_rdata | r1_rdata, 64'd0);
    check("rst_mem_addr", mem_address, 64'd0);
    check("rst_mem_wdata", mem_write_data, 64'd0);

    run_txn("st_deadbeef", 1, 0, 1, 0, 64'h10, 0, 64'hDEADBEEF, 0);
    run_txn("ld_deadbeef", 1, 0, 0, 0, 64'h10, 0, 0, 0);
    run_txn("both_ld_a", 1, 1, 0, 0, 64'h20, 64'h28, 0, 0);
    run_txn("both_ld_b", 1, 1, 0, 0, 64'h30, 64'h38, 0, 0);
    run_txn("misalign", 0, 1, 0, 0, 0, 64'h0C, 0, 0);
    run_txn("range_st", 1, 0, 1, 0, 64'h200, 0, 64'h1234, 0);
    run_txn("range_rb", 1, 0, 0, 0, 64'h1F8, 0, 0, 0);

    // Reset arriving while the store is in ISSUE must suppress the write.
    wr0 = wr_cnt;
    r0_req = 1; r0_we = 1; r0_addr = 64'h08; r0_wdata = 64'h55;
    step();
    check("rstiss_wr_pre", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    check("rstiss_wr_gated", mem_write, 1'b0);
    r0_req = 1'b0;
    step();
    reset = 1'b0;
    last_served = 1'b1;
    #1;
    check("rstiss_busy", busy, 1'b0);
    check("rstiss_ack", r0_ack, 1'b0);
    step();
    check("rstiss_ack2", r0_ack, 1'b0);
    check("rstiss_nowrite", 64'(wr_cnt - wr0), 64'd0);
    run_txn("rstiss_ld", 1, 0, 0, 0, 64'h08, 0, 0, 0);

    // Continuous request from r0: one access every three cycles.
    r0_req = 1; r0_we = 0; r0_addr = 64'h18; r0_wdata = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("stream_ack", r0_ack, (k % 3 == 2));
      check("stream_busy", busy, (k % 3 != 0));
      if (k % 3 == 2) check("stream_rdata", r0_rdata, ref_mem[3]);
    end
    r0_req = 1'b0;
    last_served = 1'b0;
    step();

    for (int it = 0; it < 40; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      run_txn("rand", pat[0], pat[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              rand_addr(), rand_addr(), {$urandom, $urandom}, {$urandom, $urandom});
    end

    for (int i = 0; i < 8; i++)
      run_txn("final_rb", 1, 0, 0, 0, {55'd0, 6'(i * 9), 3'b000}, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
